conv_acc_ctrl: RTL and testbench
================================

CONV_ACC_CTRL -- requirements
Module: conv_acc_ctrl

Interface
REQ-001 Parameter WIDTH, 64: data word width on every stream.
REQ-002 Parameter TAPS, 9: words per weight set and per image window.
REQ-003 Parameter RDEPTH, 4: result FIFO depth (power of 2).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle job start pulse.
REQ-007 cfg_num_win  in  16  windows per job, sampled on the accepted start.
REQ-008 s_data / s_valid / s_ready  in / in / out  WIDTH / 1 / 1  input stream: TAPS weight words, then cfg_num_win*TAPS image words.
REQ-009 acc_data  out  WIDTH  to Conv_acc i_Data.
REQ-010 acc_weight_setup  out  1  to Conv_acc i_Weight_setup.
REQ-011 acc_out_data / acc_out_en  in / in  WIDTH / 1  result from Conv_acc; no backpressure possible.
REQ-012 m_data / m_valid / m_ready  out / out / in  WIDTH / 1 / 1  result stream.
REQ-013 busy  out  1  high in any state except IDLE.
REQ-014 done  out  1  one-cycle pulse at job end.
REQ-015 err  out  1  sticky; cleared only by reset or by an accepted start.

Function
REQ-016 FSM states: IDLE, W_FILL, W_BURST, I_FILL, I_BURST, DRAIN, DONE.
REQ-017 IDLE: start=1 latches cfg_num_win, clears err and the window counter, and moves to W_FILL; start in any other state is ignored.
REQ-018 W_FILL / I_FILL: s_ready=1; each s_valid&s_ready handshake writes s_data to buf[k] and increments k; at k==TAPS, k clears and the state exits; s_ready=0 in all other states.
REQ-019 W_FILL exit goes to W_BURST.
REQ-020 I_FILL exit goes to I_BURST only when fifo_count+outstanding < RDEPTH; otherwise the FSM holds with s_ready=0 until credit is available.
REQ-021 W_BURST / I_BURST: exactly TAPS consecutive cycles driving acc_data=buf[0..TAPS-1]; no gaps are ever inserted within a burst.
REQ-022 acc_weight_setup=1 in IDLE, W_FILL and W_BURST; 0 in all other states.
REQ-023 acc_data=0 in every cycle outside a burst.
REQ-024 W_BURST end: cfg_num_win==0 goes to DRAIN; otherwise goes to I_FILL.
REQ-025 I_BURST last cycle: outstanding+1 and win_cnt+1; win_cnt==cfg_num_win goes to DRAIN, otherwise goes to I_FILL.
REQ-026 acc_out_en=1 with outstanding>0: pushes acc_out_data into the FIFO and decrements outstanding.
REQ-027 Issue and return in the same cycle leave outstanding unchanged.
REQ-028 acc_out_en=1 with outstanding==0: sets err and drops the data.
REQ-029 FIFO: m_valid = !empty; m_data = head word; pop on m_valid&m_ready; push and pop in the same cycle leave the count unchanged.
REQ-030 The credit rule guarantees no FIFO overflow; a push while full shall set err and drop the data.
REQ-031 DRAIN: goes to DONE when outstanding==0 (results may still sit in the FIFO); DONE lasts one cycle with done=1, then the FSM returns to IDLE.
REQ-032 win_cnt is 16 bits; cfg_num_win=0xFFFF runs to completion without wrapping.
REQ-033 Latency from the last I_FILL handshake to the first burst word is 1 cycle when credit is available.

Reset
REQ-034 rst=0 asynchronously forces IDLE and clears k, win_cnt, outstanding, fifo_count, err, done, m_valid, s_ready and acc_data; acc_weight_setup=1.
REQ-035 Reset mid-burst or with a non-empty FIFO discards all data; no m_valid is produced after release until a new job runs.

Verification
REQ-036 Nominal job: cfg_num_win=1, words W0..W8 then I0..I8 with s_valid held high, m_ready=1, model returns R after 3 cycles -> acc_weight_setup=1 during the W burst; I burst is 9 contiguous cycles with setup=0; m_data=R once; done pulses once; busy falls.
REQ-037 s_valid toggling every other cycle -> acc bursts remain 9 contiguous cycles with data identical to the input order.
REQ-038 m_ready=0, cfg_num_win=6 -> exactly 4 windows issued, then s_ready=0; release m_ready -> remaining 2 windows complete; err=0.
REQ-039 cfg_num_win=0 -> weight burst only, done pulses, no m_valid.
REQ-040 Spurious acc_out_en in IDLE -> err=1, FIFO empty; the next start clears err.
REQ-041 rst=0 during the 5th I_BURST cycle -> all outputs at reset values immediately; new job after release behaves as in REQ-036.

Source files
------------

// File: rtl/conv_acc_ctrl.sv
// Sequencer for a Conv_acc core: buffers weight and image windows from an input
// stream, replays each as a gap-free burst, and queues results under credit control.
module conv_acc_ctrl #(
  parameter int WIDTH  = 64,
  parameter int TAPS   = 9,
  parameter int RDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      cfg_num_win,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] acc_data,
  output logic             acc_weight_setup,
  input  logic [WIDTH-1:0] acc_out_data,
  input  logic             acc_out_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int KW = $clog2(TAPS + 1);
  localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW = $clog2(RDEPTH + 1);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

  typedef enum logic [2:0] {
    IDLE, W_FILL, W_BURST, I_FILL, I_BURST, DRAIN, DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] tap_buf  [TAPS];
  logic [WIDTH-1:0] fifo_mem [RDEPTH];
  logic [KW-1:0]    k;
  logic [15:0]      num_win;
  logic [15:0]      win_cnt;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    fifo_count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  logic burst;
  logic s_fire;
  logic k_last;
  logic job_start;
  logic issue;
  logic ret_ok;
  logic fifo_full;
  logic push;
  logic pop;
  logic credit_ok;
  logic err_set;

  assign s_fire    = s_valid & s_ready;
  assign k_last    = (k == K_LAST);
  assign job_start = (state == IDLE) && start;
  assign issue     = (state == I_BURST) && k_last;
  assign ret_ok    = acc_out_en && (outstanding != '0);
  assign fifo_full = (fifo_count == CW'(RDEPTH));
  assign push      = ret_ok && !fifo_full;
  assign pop       = m_valid && m_ready;
  assign err_set   = (acc_out_en && (outstanding == '0)) || (ret_ok && fifo_full);

  // Every in-flight window owns a FIFO slot, so results can never overflow it.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CW + 1)'(RDEPTH);

  assign acc_data = burst ? tap_buf[k] : '0;
  assign m_valid  = (fifo_count != '0);
  assign m_data   = fifo_mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt        = state;
    s_ready          = 1'b0;
    acc_weight_setup = 1'b0;
    burst            = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    unique case (state)
      IDLE: begin
        busy             = 1'b0;
        acc_weight_setup = 1'b1;
        if (start) state_nxt = W_FILL;
      end
      W_FILL: begin
        acc_weight_setup = 1'b1;
        s_ready          = 1'b1;
        if (s_valid && k_last) state_nxt = W_BURST;
      end
      W_BURST: begin
        acc_weight_setup = 1'b1;
        burst            = 1'b1;
        if (k_last) state_nxt = (num_win == 16'd0) ? DRAIN : I_FILL;
      end
      I_FILL: begin
        s_ready = credit_ok;
        if (s_valid && credit_ok && k_last) state_nxt = I_BURST;
      end
      I_BURST: begin
        burst = 1'b1;
        if (k_last) state_nxt = ((win_cnt + 16'd1) == num_win) ? DRAIN : I_FILL;
      end
      DRAIN: begin
        if (outstanding == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // k indexes the buffer both while filling and while replaying a burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  k <= '0;
    else if (state == IDLE)    k <= '0;
    else if (s_fire || burst)  k <= k_last ? '0 : k + KW'(1);
  end

  // NOTE: data arrays carry no reset; the counters that qualify them do.
  always_ff @(posedge clk) begin
    if (s_fire) tap_buf[k] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_win <= '0;
      win_cnt <= '0;
    end else if (job_start) begin
      num_win <= cfg_num_win;
      win_cnt <= '0;
    end else if (issue) begin
      win_cnt <= win_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      unique case ({issue, ret_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= acc_out_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // A fault in the same cycle as a start still leaves err set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           err <= 1'b0;
    else if (err_set)   err <= 1'b1;
    else if (job_start) err <= 1'b0;
  end

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// Scoreboard bench for conv_acc_ctrl with a behavioural Conv_acc that returns
// a dot-product result three cycles after each image burst.
module tb_conv_acc_ctrl;

  localparam int WIDTH  = 64;
  localparam int TAPS   = 9;
  localparam int RDEPTH = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             setup;
  } acc_exp_t;

  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } ret_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [15:0]      cfg_num_win = '0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] acc_data;
  logic             acc_weight_setup;
  logic [WIDTH-1:0] acc_out_data = '0;
  logic             acc_out_en = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic             busy;
  logic             done;
  logic             err;

  int total = 0;
  int bad   = 0;

  acc_exp_t         exp_acc [$];
  logic [WIDTH-1:0] exp_res [$];
  ret_t             pend    [$];

  logic [WIDTH-1:0] seen_w [TAPS];
  logic [WIDTH-1:0] seen_x [TAPS];
  int               run_len     = 0;
  int               cyc         = 0;
  int               img_words   = 0;
  int               img_windows = 0;
  int               mv_cycles   = 0;
  acc_exp_t         m_e;
  ret_t             m_r;
  logic [WIDTH-1:0] m_sum;

  conv_acc_ctrl #(.WIDTH(WIDTH), .TAPS(TAPS), .RDEPTH(RDEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_num_win      (cfg_num_win),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .acc_data         (acc_data),
    .acc_weight_setup (acc_weight_setup),
    .acc_out_data     (acc_out_data),
    .acc_out_en       (acc_out_en),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  function automatic logic [63:0] wgt_word(input int j, input int i);
    return {16'hC0DE, 16'(j), 16'h0000, 16'(i + 1)};
  endfunction

  function automatic logic [63:0] img_word(input int j, input int w, input int t);
    return {16'h1234, 16'(j), 16'(w), 16'(t + 1)};
  endfunction

  // Behavioural Conv_acc: consumes bursts, checks them, returns results.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      run_len      = 0;
      acc_out_en   = 1'b0;
      acc_out_data = '0;
    end else begin
      if (acc_data != '0) begin
        if (exp_acc.size() == 0) begin
          fail_now("acc_unexpected_word", acc_data);
        end else begin
          m_e = exp_acc.pop_front();
          check("acc_data", acc_data, m_e.data);
          check("acc_setup", 64'(acc_weight_setup), 64'(m_e.setup));
        end
        if (run_len < TAPS) begin
          if (acc_weight_setup) seen_w[run_len] = acc_data;
          else                  seen_x[run_len] = acc_data;
        end
        if (!acc_weight_setup) img_words++;
        run_len++;
        if (run_len == TAPS && !acc_weight_setup) begin
          m_sum = '0;
          for (int t = 0; t < TAPS; t++) m_sum += seen_w[t] * seen_x[t];
          m_r.due  = cyc + 3;
          m_r.data = m_sum;
          pend.push_back(m_r);
          img_windows++;
        end
      end else if (run_len != 0) begin
        check("burst_len", 64'(run_len), 64'(TAPS));
        run_len = 0;
      end
      acc_out_en = 1'b0;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        m_r          = pend.pop_front();
        acc_out_en   = 1'b1;
        acc_out_data = m_r.data;
      end
    end
  end

  // Result monitor.
  always @(negedge clk) begin
    if (rst && m_valid) begin
      mv_cycles++;
      if (m_ready) begin
        if (exp_res.size() == 0) fail_now("m_unexpected", m_data);
        else                     check("m_data", m_data, exp_res.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] d, input bit gap);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail_now("s_ready_timeout", 64'(n));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    @(posedge clk);
    #1;
    start       = 1'b1;
    cfg_num_win = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("err_after_start", 64'(err), 64'(0));
  endtask

  task automatic run_job(input int j, input int nwin, input bit gap, input bit chk_lat);
    logic [63:0] w [TAPS];
    logic [63:0] x [TAPS];
    logic [63:0] r;
    acc_exp_t    e;
    int          n;
    do_start(16'(nwin));
    for (int i = 0; i < TAPS; i++) begin
      w[i]    = wgt_word(j, i);
      e.data  = w[i];
      e.setup = 1'b1;
      exp_acc.push_back(e);
      send(w[i], gap);
    end
    for (int win = 0; win < nwin; win++) begin
      r = '0;
      for (int t = 0; t < TAPS; t++) begin
        x[t]    = img_word(j, win, t);
        r      += w[t] * x[t];
        e.data  = x[t];
        e.setup = 1'b0;
        exp_acc.push_back(e);
        send(x[t], gap);
      end
      exp_res.push_back(r);
      if (chk_lat && win == 0) begin
        @(negedge clk);
        check("issue_latency", acc_data, x[0]);
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 64'(done), 64'(1));
    @(negedge clk);
    check("done_width", 64'(done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("results_left", 64'(exp_res.size()), 64'(0));
    check("acc_words_left", 64'(exp_acc.size()), 64'(0));
    check("err_end", 64'(err), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_win;
    int base_mv;
    int base_words;
    int n;
    acc_exp_t e;
    ret_t     sp;

    // Reset values.
    #3;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_acc_data", acc_data, 64'(0));
    check("rst_setup", 64'(acc_weight_setup), 64'(1));
    #29;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal single-window job.
    run_job(1, 1, 1'b0, 1'b1);

    // s_valid toggling every other cycle.
    run_job(2, 2, 1'b1, 1'b0);

    // Backpressure: only RDEPTH windows may be in flight or buffered.
    m_ready  = 1'b0;
    base_win = img_windows;
    fork
      run_job(3, 6, 1'b0, 1'b0);
      begin
        repeat (200) @(negedge clk);
        check("bp_windows_held", 64'(img_windows - base_win), 64'(4));
        check("bp_s_ready", 64'(s_ready), 64'(0));
        check("bp_m_valid", 64'(m_valid), 64'(1));
        check("bp_busy", 64'(busy), 64'(1));
        m_ready = 1'b1;
      end
    join
    check("bp_windows_total", 64'(img_windows - base_win), 64'(6));

    // Zero windows: weight burst only.
    base_win = img_windows;
    base_mv  = mv_cycles;
    run_job(4, 0, 1'b0, 1'b0);
    check("zero_win_windows", 64'(img_windows - base_win), 64'(0));
    check("zero_win_m_valid", 64'(mv_cycles - base_mv), 64'(0));

    // Spurious result while idle.
    @(negedge clk);
    #1;
    sp.due  = cyc + 1;
    sp.data = 64'hDEAD_BEEF_0000_0001;
    pend.push_back(sp);
    repeat (3) @(negedge clk);
    check("spurious_err", 64'(err), 64'(1));
    check("spurious_m_valid", 64'(m_valid), 64'(0));
    run_job(5, 1, 1'b0, 1'b1);

    // Reset in the 5th image-burst cycle.
    do_start(16'd1);
    for (int i = 0; i < TAPS; i++) begin
      e.data  = wgt_word(6, i);
      e.setup = 1'b1;
      exp_acc.push_back(e);
      send(e.data, 1'b0);
    end
    base_words = img_words;
    for (int t = 0; t < TAPS; t++) begin
      e.data  = img_word(6, 0, t);
      e.setup = 1'b0;
      exp_acc.push_back(e);
      send(e.data, 1'b0);
    end
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (img_words < base_words + 5 && n < 100);
    check("rst_mid_sync", 64'(img_words - base_words), 64'(5));
    rst = 1'b0;
    #1;
    check("mid_rst_acc_data", acc_data, 64'(0));
    check("mid_rst_setup", 64'(acc_weight_setup), 64'(1));
    check("mid_rst_s_ready", 64'(s_ready), 64'(0));
    check("mid_rst_m_valid", 64'(m_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    exp_acc.delete();
    exp_res.delete();
    pend.delete();
    repeat (2) @(negedge clk);
    #2;
    rst     = 1'b1;
    base_mv = mv_cycles;
    repeat (6) @(negedge clk);
    check("post_rst_m_valid", 64'(mv_cycles - base_mv), 64'(0));
    check("post_rst_err", 64'(err), 64'(0));
    run_job(7, 1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
